joint_step_driver: RTL and testbench

JOINT_STEP_DRIVER -- requirements
Module: joint_step_driver

---
 rtl/joint_step_driver.sv | 123 ++++++++++++
 tb/tb_joint_step_driver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joint_step_driver.sv
// Stepper driver for one robot joint: converts a Q3.10 radian angle into a step
// target and walks the position there with timed dir/step pulses.
module joint_step_driver #(
    parameter int STEPS_PER_RAD = 1019,
    parameter int DIR_SETUP     = 8,
    parameter int PULSE_WIDTH   = 50,
    parameter int STEP_PERIOD   = 500
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [12:0] angle,
    input  logic               angle_valid,
    input  logic               home,
    output logic               step,
    output logic               dir,
    output logic signed [15:0] position,
    output logic               busy,
    output logic               done,
    output logic [2:0]         fsm_state
);

    // Handshake: angle_valid is a one-cycle strobe with no ready; a strobe is never
    // dropped silently -- it is captured in IDLE, otherwise held in the last-wins pending slot.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETUP   = 3'd2,
        STEP_HI = 3'd3,
        STEP_LO = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic [11:0] SPR        = 12'(STEPS_PER_RAD);
    localparam logic [15:0] SETUP_LAST = 16'(DIR_SETUP - 1);
    localparam logic [15:0] HI_LAST    = 16'(PULSE_WIDTH - 1);
    localparam logic [15:0] LO_LAST    = 16'(STEP_PERIOD - PULSE_WIDTH - 1);

    state_t             state;
    state_t             next_state;
    logic [15:0]        cnt;
    logic signed [15:0] target;
    logic signed [15:0] pending_target;
    logic               pending;

    // Floor of angle*SPR/1024: the arithmetic shift rounds toward minus infinity.
    function automatic logic signed [15:0] to_steps(input logic signed [12:0] a);
        logic signed [24:0] prod;
        logic signed [24:0] shifted;
        prod    = $signed({{12{a[12]}}, a}) * $signed({13'd0, SPR});
        shifted = prod >>> 10;
        return shifted[15:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (angle_valid) next_state = LOAD;
            LOAD:    next_state = (target == position) ? FINISH : SETUP;
            SETUP:   if (cnt == SETUP_LAST) next_state = STEP_HI;
            STEP_HI: if (cnt == HI_LAST) next_state = STEP_LO;
            STEP_LO: if (cnt == LO_LAST) next_state = (position == target) ? FINISH : STEP_HI;
            FINISH:  next_state = (pending || angle_valid) ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            target         <= '0;
            pending_target <= '0;
            pending        <= 1'b0;
            position       <= '0;
            dir            <= 1'b0;
        end else begin
            cnt <= (next_state != state) ? 16'd0 : cnt + 16'd1;
            case (state)
                IDLE: begin
                    // home clears position first, so a coincident capture is compared against 0
                    if (home) position <= '0;
                    if (angle_valid) target <= to_steps(angle);
                end
                LOAD: begin
                    if (target != position) dir <= (target > position);
                end
                FINISH: begin
                    if (angle_valid) begin
                        target  <= to_steps(angle);
                        pending <= 1'b0;
                    end else if (pending) begin
                        target  <= pending_target;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    if (angle_valid) begin
                        pending_target <= to_steps(angle);
                        pending        <= 1'b1;
                    end
                end
            endcase
            // position moves on the same edge that raises step
            if (next_state == STEP_HI && state != STEP_HI) begin
                position <= dir ? position + 16'sd1 : position - 16'sd1;
            end
        end
    end

    assign step      = (state == STEP_HI);
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign fsm_state = state;

endmodule

// File: tb/tb_joint_step_driver.sv
// Bench for joint_step_driver: move results are queued as {dir, pulses, position}
// when strobed and compared on each done pulse; pulse timing is checked live.
module tb_joint_step_driver;

    localparam int W = 25;

    logic               clk;
    logic               reset;
    logic signed [12:0] angle;
    logic               angle_valid;
    logic               home;
    logic               step;
    logic               dir;
    logic signed [15:0] position;
    logic               busy;
    logic               done;
    logic [2:0]         fsm_state;

    logic [W-1:0] exp_q[$];
    int checks;
    int passes;

    joint_step_driver #(
        .STEPS_PER_RAD(16),
        .DIR_SETUP    (2),
        .PULSE_WIDTH  (2),
        .STEP_PERIOD  (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .angle      (angle),
        .angle_valid(angle_valid),
        .home       (home),
        .step       (step),
        .dir        (dir),
        .position   (position),
        .busy       (busy),
        .done       (done),
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Live monitor: pulse shape and the scoreboard pop on done.
    logic         prev_step;
    logic         first_pulse;
    int           pulses;
    int           hi_len;
    int           per;
    logic [W-1:0] got;
    logic [W-1:0] want;

    always @(negedge clk) begin
        if (reset) begin
            prev_step   = 1'b0;
            first_pulse = 1'b1;
            pulses      = 0;
            hi_len      = 0;
            per         = 0;
        end else begin
            per++;
            if (step && !prev_step) begin
                pulses++;
                if (!first_pulse) begin
                    checks++;
                    if (per !== 5) $display("FAIL step_period got %0d want 5", per);
                    else passes++;
                end
                first_pulse = 1'b0;
                per = 0;
            end
            if (step) hi_len++;
            if (!step && prev_step) begin
                checks++;
                if (hi_len !== 2) $display("FAIL step_high_len got %0d want 2", hi_len);
                else passes++;
                hi_len = 0;
            end
            prev_step = step;
            if (done) begin
                got = {dir, 8'(pulses), position};
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_done got dir=%0b pulses=%0d pos=%0d want no done",
                             dir, pulses, position);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want)
                        $display("FAIL move_result got dir=%0b pulses=%0d pos=%0d want dir=%0b pulses=%0d pos=%0d",
                                 got[24], got[23:16], $signed(got[15:0]),
                                 want[24], want[23:16], $signed(want[15:0]));
                    else passes++;
                end
                pulses      = 0;
                first_pulse = 1'b1;
            end
        end
    end

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) $display("FAIL done_timeout got no done want done within %0d cycles", limit);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1; angle = '0; angle_valid = 1'b0; home = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (step !== 1'b0) $display("FAIL reset_step got %0b want 0", step); else passes++;
        if (dir !== 1'b0) $display("FAIL reset_dir got %0b want 0", dir); else passes++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passes++;
        if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passes++;
        if (position !== 16'sd0) $display("FAIL reset_position got %0d want 0", position); else passes++;
        if (fsm_state !== 3'd0) $display("FAIL reset_state got %0d want 0", fsm_state); else passes++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_first_move();
        int n;
        exp_q.push_back({1'b1, 8'd16, 16'sd16});
        @(posedge clk); #1;
        angle = 13'sd1024; angle_valid = 1'b1;
        n = 0;
        while (step !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            angle_valid = 1'b0;
            n++;
        end
        checks++;
        if (n !== 4) $display("FAIL first_rise_latency got %0d want 4", n); else passes++;
        wait_done(300);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_after_done got %0b want 0", busy); else passes++;
    endtask

    task automatic test_negative_move();
        exp_q.push_back({1'b0, 8'd25, -16'sd9});
        @(posedge clk); #1;
        angle = -13'sd520; angle_valid = 1'b1;
        @(posedge clk); #1;
        angle_valid = 1'b0;
        wait_done(300);
        @(negedge clk);
    endtask

    task automatic test_equal_target();
        int n;
        exp_q.push_back({1'b0, 8'd0, -16'sd9});
        @(posedge clk); #1;
        angle = -13'sd576; angle_valid = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            angle_valid = 1'b0;
            n++;
        end
        checks += 2;
        if (n !== 2) $display("FAIL equal_done_latency got %0d want 2", n); else passes++;
        if (dir !== 1'b0) $display("FAIL equal_dir_held got %0b want 0", dir); else passes++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   n;
        logic dropped;
        dropped = 1'b0;
        exp_q.push_back({1'b1, 8'd1, -16'sd8});
        @(posedge clk); #1;
        angle = -13'sd512; angle_valid = 1'b1;
        @(posedge clk); #1;
        angle_valid = 1'b0;
        @(posedge clk); #1;
        angle = 13'sd256; angle_valid = 1'b1;
        @(posedge clk); #1;
        angle_valid = 1'b0;
        exp_q.push_back({1'b1, 8'd16, 16'sd8});
        angle = 13'sd512; angle_valid = 1'b1;
        @(posedge clk); #1;
        angle_valid = 1'b0; angle = '0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            if (!busy) dropped = 1'b1;
            n++;
        end
        @(negedge clk);
        checks++;
        if (fsm_state !== 3'd1) $display("FAIL chain_to_load got state=%0d want 1", fsm_state); else passes++;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            if (!busy) dropped = 1'b1;
            @(negedge clk);
            n++;
        end
        checks += 2;
        if (done !== 1'b1) $display("FAIL chain_done_timeout got no done want done"); else passes++;
        if (dropped !== 1'b0) $display("FAIL chain_busy_held got dropped=%0b want 0", dropped); else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        @(posedge clk); #1;
        angle = 13'sd1024; angle_valid = 1'b1;
        @(posedge clk); #1;
        angle_valid = 1'b0;
        n = 0;
        while (step !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (step !== 1'b1) $display("FAIL reset_mid_no_pulse got step=0 want 1"); else passes++;
        #1 reset = 1'b1;
        #1;
        checks += 3;
        if (step !== 1'b0) $display("FAIL async_step got %0b want 0", step); else passes++;
        if (position !== 16'sd0) $display("FAIL async_position got %0d want 0", position); else passes++;
        if (busy !== 1'b0) $display("FAIL async_busy got %0b want 0", busy); else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        exp_q.push_back({1'b1, 8'd1, 16'sd1});
        @(posedge clk); #1;
        home = 1'b1; angle = 13'sd64; angle_valid = 1'b1;
        @(posedge clk); #1;
        home = 1'b0; angle_valid = 1'b0;
        wait_done(100);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_first_move();
        test_negative_move();
        test_equal_target();
        test_back_to_back();
        test_reset_mid_pulse();
        checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
